// File: rtl/stream_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// stream_pkg : shared lane constants and bus-slicing helpers
// Rev 1.0
// ------------------------------------------------------------------
package stream_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  // LSB of lane 'lane' inside a flattened bus of 'w'-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

  function automatic logic [LANES-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [LANES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_lane_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// demux_lane_fifo : per-lane FIFO with registered push and head output
// Rev 1.0
// ------------------------------------------------------------------
module demux_lane_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    // Remember the departing head so an empty lane keeps showing it.
    if (do_pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  assign valid     = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = valid ? mem_q[rd_ptr_q] : last_q;

endmodule
`default_nettype wire

// File: rtl/stream_demux4.sv
`default_nettype none
// ------------------------------------------------------------------
// stream_demux4 : 1-to-4 valid/ready stream demux with per-lane FIFOs
// Rev 1.0
// ------------------------------------------------------------------
module stream_demux4
  import stream_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*CW-1:0]    lane_count
);

  logic [LANES-1:0] full;
  logic [LANES-1:0] push_en;

  // Ready looks only at registered fullness, never at out_ready.
  always_comb begin
    in_ready = rst_n && !full[in_sel];
    push_en  = (in_valid && in_ready) ? sel_onehot(in_sel) : '0;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_en[i]),
      .push_data (in_data),
      .pop       (out_ready[i]),
      .head_data (out_data[lane_lsb(i, WIDTH) +: WIDTH]),
      .valid     (out_valid[i]),
      .full      (full[i]),
      .count     (lane_count[lane_lsb(i, CW) +: CW])
    );
  end

endmodule
`default_nettype wire
